capture_wr_queue: RTL and testbench

- Sits directly downstream of the camera capture stage in the p_clk domain, upstream of the DDR write arbiter.
- Buffers the 128-bit pixel words and their 25-bit write addresses in a synchronous FIFO.
- Presents the words to the memory side with a valid/ready handshake.
- Tracks frame boundaries and issues a frame-ready pulse with the completed buffer index once every word of a frame has left the queue, so downstream HDR logic knows a frame is fully committed.

---
 rtl/capture_wr_queue.sv | 118 +++++++++++
 tb/tb_capture_wr_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_wr_queue.sv
// capture_wr_queue: FIFO between the capture stage and the DDR write arbiter.
// It counts the words in each frame and pulses frame_ready once every word of the closed frame has left the queue.
module capture_wr_queue #(
    parameter int DEPTH     = 16,
    parameter int DW        = 128,
    parameter int AW        = 25,
    parameter int EXP_WORDS = 38400
) (
    input  logic                   p_clk,
    input  logic                   rst_n,
    input  logic [DW-1:0]          in_data,
    input  logic [AW-1:0]          in_addr,
    input  logic                   in_valid,
    input  logic                   frame_sync,
    input  logic                   buf_sel,
    input  logic                   clr_err,
    output logic [DW-1:0]          wr_data,
    output logic [AW-1:0]          wr_addr,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   drain_err,
    output logic                   frame_ready,
    output logic                   frame_buf,
    output logic                   frame_ok
);
    localparam int LW = $clog2(DEPTH);
    localparam logic [LW:0] FULL = (LW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, CLOSE} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     data_mem [DEPTH];
    logic [AW-1:0]     addr_mem [DEPTH];
    logic [LW-1:0]     wptr_q, rptr_q;
    logic [LW:0]       level_q, pend_q, pend_d;
    logic [16:0]       cur_cnt_q, cur_cnt_d, close_cnt_q, close_cnt_d;
    logic              cur_buf_q, cur_buf_d, close_buf_q, close_buf_d;
    logic              ovf_q, derr_q, push, pop, drop, drain_set;

    assign wr_valid    = level_q != '0;
    assign pop         = wr_valid && wr_ready;
    assign push        = in_valid && state_q != IDLE && (level_q < FULL || pop);
    assign drop        = in_valid && state_q != IDLE && !push;
    assign wr_data     = wr_valid ? data_mem[rptr_q] : '0;
    assign wr_addr     = wr_valid ? addr_mem[rptr_q] : '0;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign drain_err   = derr_q;
    assign frame_ready = state_q == CLOSE && pend_q == '0;
    assign frame_buf   = frame_ready && close_buf_q;
    assign frame_ok    = frame_ready && close_cnt_q == 17'(EXP_WORDS);

    always_ff @(posedge p_clk) begin
        if (push) begin
            data_mem[wptr_q] <= in_data;
            addr_mem[wptr_q] <= in_addr;
        end
    end

    // A push that coincides with frame_sync counts toward the frame now starting.
    always_comb begin
        state_d     = state_q;
        cur_buf_d   = cur_buf_q;
        close_buf_d = close_buf_q;
        close_cnt_d = close_cnt_q;
        pend_d      = pend_q;
        drain_set   = 1'b0;
        cur_cnt_d   = (push && cur_cnt_q != '1) ? cur_cnt_q + 17'd1 : cur_cnt_q;
        if (state_q == IDLE) begin
            if (frame_sync) begin
                state_d   = RUN;
                cur_buf_d = buf_sel;
                cur_cnt_d = '0;
            end
        end else if (frame_sync) begin
            state_d     = CLOSE;
            close_buf_d = cur_buf_q;
            close_cnt_d = cur_cnt_q;
            pend_d      = level_q - (LW+1)'(pop);
            cur_buf_d   = buf_sel;
            cur_cnt_d   = 17'(push);
            drain_set   = state_q == CLOSE && pend_q != '0;
        end else if (state_q == CLOSE) begin
            pend_d  = pend_q - (LW+1)'(pop && pend_q != '0);
            state_d = pend_q == '0 ? RUN : CLOSE;
        end
    end

    always_ff @(posedge p_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            pend_q      <= '0;
            cur_cnt_q   <= '0;
            close_cnt_q <= '0;
            cur_buf_q   <= 1'b0;
            close_buf_q <= 1'b0;
            ovf_q       <= 1'b0;
            derr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_q + LW'(push);
            rptr_q      <= rptr_q + LW'(pop);
            level_q     <= level_q + (LW+1)'(push) - (LW+1)'(pop);
            pend_q      <= pend_d;
            cur_cnt_q   <= cur_cnt_d;
            close_cnt_q <= close_cnt_d;
            cur_buf_q   <= cur_buf_d;
            close_buf_q <= close_buf_d;
            ovf_q       <= drop || (ovf_q && !clr_err);
            derr_q      <= drain_set || (derr_q && !clr_err);
        end
    end
endmodule

// File: tb/tb_capture_wr_queue.sv
// tb_capture_wr_queue: directed stimulus against a frame-tagged queue model of capture_wr_queue.
// Each queued word carries the sequence number of its frame, so a closed frame has drained once no word of its sequence or an earlier one remains.
module tb_capture_wr_queue;
    localparam int DEPTH = 16;
    localparam int EXPW  = 38400;

    logic         p_clk, rst_n, in_valid, frame_sync, buf_sel, clr_err, wr_ready;
    logic [127:0] in_data, wr_data;
    logic [24:0]  in_addr, wr_addr;
    logic         wr_valid, overflow, drain_err, frame_ready, frame_buf, frame_ok;
    logic [4:0]   level;

    capture_wr_queue dut (
        .p_clk(p_clk), .rst_n(rst_n), .in_data(in_data), .in_addr(in_addr),
        .in_valid(in_valid), .frame_sync(frame_sync), .buf_sel(buf_sel),
        .clr_err(clr_err), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .level(level),
        .overflow(overflow), .drain_err(drain_err), .frame_ready(frame_ready),
        .frame_buf(frame_buf), .frame_ok(frame_ok)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    typedef struct {
        logic [127:0] d;
        logic [24:0]  a;
        int           seq;
    } ent_t;

    ent_t q[$];
    int   checks = 0, failures = 0;
    int   cur_seq, pend_seq, cur_cnt, pend_cnt;
    logic cur_buf, pend_buf, pend_v, running, ovf_m, derr_m, en = 1'b0;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic fr_exp();
        return pend_v && (q.size() == 0 || q[0].seq > pend_seq);
    endfunction

    function automatic logic [127:0] mk(input int id);
        logic [31:0] w;
        w = 32'(id) ^ 32'hA5A5_0000;
        return {w, ~w, w + 32'd1, w ^ 32'h5A};
    endfunction

    always @(posedge p_clk) begin
        logic pop, fr, acc, drop, dset;
        if (!rst_n) begin
            q.delete();
            running = 0; pend_v = 0; ovf_m = 0; derr_m = 0;
            cur_cnt = 0; cur_seq = 0; cur_buf = 0; pend_buf = 0; pend_cnt = 0; pend_seq = 0;
        end else begin
            pop  = q.size() != 0 && wr_ready;
            fr   = fr_exp();
            acc  = running && in_valid && (q.size() < DEPTH || pop);
            drop = running && in_valid && !acc;
            dset = 0;
            if (frame_sync) begin
                if (running) begin
                    dset     = pend_v && !fr;
                    pend_v   = 1;
                    pend_seq = cur_seq;
                    pend_buf = cur_buf;
                    pend_cnt = cur_cnt;
                end
                running = 1;
                cur_seq++;
                cur_buf = buf_sel;
                cur_cnt = 0;
            end else if (fr) pend_v = 0;
            ovf_m  = drop || (ovf_m && !clr_err);
            derr_m = dset || (derr_m && !clr_err);
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back('{in_data, in_addr, cur_seq});
                if (cur_cnt < 131071) cur_cnt++;
            end
        end
    end

    always @(negedge p_clk) begin
        if (en) begin
            logic fr;
            fr = fr_exp();
            chk("wr_valid", wr_valid, q.size() != 0);
            chk("wr_data", wr_data, q.size() != 0 ? q[0].d : 128'd0);
            chk("wr_addr", wr_addr, q.size() != 0 ? q[0].a : 25'd0);
            chk("level", level, q.size());
            chk("overflow", overflow, ovf_m);
            chk("drain_err", drain_err, derr_m);
            chk("frame_ready", frame_ready, fr);
            chk("frame_buf", frame_buf, fr && pend_buf);
            chk("frame_ok", frame_ok, fr && pend_cnt == EXPW);
        end
    end

    task automatic drive(input logic iv, input int id, input logic fs, input logic bs,
                         input logic rdy, input logic clr);
        in_valid = iv; in_data = mk(id); in_addr = 25'(id * 4);
        frame_sync = fs; buf_sel = bs; wr_ready = rdy; clr_err = clr;
        @(posedge p_clk);
        #1;
    endtask

    initial begin
        logic seen;
        rst_n = 0; in_valid = 0; in_data = '0; in_addr = '0;
        frame_sync = 0; buf_sel = 0; clr_err = 0; wr_ready = 0;
        drive(0, 0, 0, 0, 0, 0);
        en = 1;
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_level", level, 0);
        chk("rst_valid", wr_valid, 0);
        rst_n = 1;

        // 1: three words through an idle-ready queue
        drive(0, 0, 1, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0);
        chk("t1_valid_after_push", wr_valid, 1);
        chk("t1_head_addr", wr_addr, 0);
        drive(1, 1, 0, 0, 1, 0);
        drive(1, 2, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("t1_level_empty", level, 0);

        // 2: fill, overflow, clear
        for (int i = 0; i < 16; i++) drive(1, 100 + i, 0, 0, 0, 0);
        chk("t2_level_full", level, 16);
        drive(1, 116, 0, 0, 0, 0);
        chk("t2_overflow", overflow, 1);
        chk("t2_level_still_full", level, 16);
        drive(0, 0, 0, 0, 0, 1);
        chk("t2_overflow_clr", overflow, 0);

        // 3: push and pop at full
        drive(1, 117, 0, 0, 1, 0);
        chk("t3_level", level, 16);
        chk("t3_no_ovf", overflow, 0);
        chk("t3_head_addr", wr_addr, 101 * 4);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 1, 0);
        chk("t3_drained", level, 0);

        // 4a: full-length frame closed with 5 words still queued
        drive(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < EXPW - 5; i++) drive(1, 1000 + i, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 50000 + i, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0);
        chk("t4_no_pulse_at_close", frame_ready, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            chk("t4_no_early_pulse", frame_ready, 0);
        end
        drive(0, 0, 0, 0, 1, 0);
        chk("t4_pulse", frame_ready, 1);
        chk("t4_buf", frame_buf, 0);
        chk("t4_ok", frame_ok, 1);

        // 4b: one word short
        for (int i = 0; i < EXPW - 1; i++) drive(1, 60000 + i, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 0);
        chk("t4b_pulse", frame_ready, 1);
        chk("t4b_buf", frame_buf, 1);
        chk("t4b_not_ok", frame_ok, 0);
        drive(0, 0, 0, 0, 0, 0);

        // 5: second close while the first is still draining
        for (int i = 0; i < 3; i++) drive(1, 200 + i, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) drive(1, 210 + i, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("t5_drain_err", drain_err, 1);
        chk("t5_no_pulse", frame_ready, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            if (frame_ready) begin
                seen = 1;
                chk("t5_buf", frame_buf, 1);
            end
        end
        chk("t5_pulse_seen", seen, 1);
        drive(0, 0, 0, 0, 1, 1);
        chk("t5_err_clr", drain_err, 0);

        // 6: reset with words queued
        for (int i = 0; i < 8; i++) drive(1, 300 + i, 0, 0, 0, 0);
        chk("t6_level8", level, 8);
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_valid", wr_valid, 0);
        rst_n = 1;
        for (int i = 0; i < 3; i++) drive(1, 400 + i, 0, 0, 0, 0);
        chk("t6_idle_ignores", level, 0);
        drive(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) drive(1, 410 + i, 0, 0, 0, 0);
        chk("t6_run_level", level, 2);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);
        chk("t6_final_empty", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
